// File: rtl/button_fsm.sv
// button_fsm: synchronized, debounced push-button front end driving an IDLE/RUN/STEP counter FSM.
`timescale 1ns/1ps
module button_fsm #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int RUN_DIV         = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] button,
  output logic       led_start_stop,
  output logic       led_step,
  output logic [3:0] led_run
);
  typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;
  localparam logic [7:0]  DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] RUN_LAST = 16'(RUN_DIV - 1);
  state_t          state_q, state_d;
  logic [4:0]      sync1_q, sync2_q, db_q, db_d, db_prev_q, ev;
  logic [4:0][7:0] cnt_q, cnt_d;
  logic [3:0]      ctr_q, ctr_d;
  logic [15:0]     pre_q, pre_d;
  logic            run_led_q, step_led_q;
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = (sync2_q[i] == db_q[i] || cnt_q[i] == DB_LAST) ? '0 : cnt_q[i] + 8'd1;
      db_d[i]  = (sync2_q[i] != db_q[i] && cnt_q[i] == DB_LAST) ? sync2_q[i] : db_q[i];
    end
  end
  assign ev = db_q & ~db_prev_q;
  // Priority halt > start/stop > step > clear; bit 3 is reserved and matches only as don't-care.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    pre_d   = pre_q;
    case (state_q)
      IDLE: casez (ev)
        5'b1????: state_d = IDLE;
        5'b0???1: begin
          state_d = RUN;
          pre_d   = '0;
        end
        5'b0??10: state_d = STEP;
        5'b0?100: ctr_d = '0;
        default: ;
      endcase
      RUN: begin
        if (ev[4] || ev[0]) state_d = IDLE;
        else if (pre_q == RUN_LAST) begin
          pre_d = '0;
          ctr_d = ctr_q + 4'd1;
        end else pre_d = pre_q + 16'd1;
      end
      STEP: begin
        state_d = IDLE;
        ctr_d   = ctr_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q    <= IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      db_prev_q  <= '0;
      cnt_q      <= '0;
      ctr_q      <= '0;
      pre_q      <= '0;
      run_led_q  <= 1'b0;
      step_led_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= button;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      db_prev_q  <= db_q;
      cnt_q      <= cnt_d;
      ctr_q      <= ctr_d;
      pre_q      <= pre_d;
      run_led_q  <= state_d == RUN;
      step_led_q <= state_d == STEP;
    end
  end
  assign led_start_stop = run_led_q;
  assign led_step       = step_led_q;
  assign led_run        = ctr_q;
endmodule

// File: tb/tb_button_fsm.sv
// tb_button_fsm: directed checks of button_fsm at default parameters with a 2 ns clock.
`timescale 1ns/1ps
module tb_button_fsm;
  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] button;
  logic       led_start_stop, led_step;
  logic [3:0] led_run;
  int errors = 0;
  int checks = 0;
  int steps, ss_seen;

  button_fsm dut (
    .clk(clk), .resetn(resetn), .button(button),
    .led_start_stop(led_start_stop), .led_step(led_step), .led_run(led_run)
  );

  always #1 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int b, input int h);
    button[b] = 1'b1;
    wait_n(h);
    button[b] = 1'b0;
  endtask

  initial begin
    resetn = 1'b1;
    button = '0;
    wait_n(3);
    chk("rst_ss", led_start_stop, 0);
    chk("rst_step", led_step, 0);
    chk("rst_run", led_run, 0);
    resetn = 1'b0;
    wait_n(1);
    chk("post_rst_ss", led_start_stop, 0);
    // start: state changes exactly 5 edges after the input rise
    button[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_n(1);
      chk("start_latency", led_start_stop, 0);
    end
    wait_n(1);
    chk("start_ss", led_start_stop, 1);
    chk("start_run0", led_run, 0);
    button[0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      wait_n(1);
      chk("run_count", led_run, k % 16);
    end
    // halt: four more increments before the event lands, then frozen at 8
    button[4] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_n(1);
      chk("halt_ss_still", led_start_stop, 1);
      chk("halt_count", led_run, (20 + k) % 16);
    end
    wait_n(1);
    chk("halt_ss", led_start_stop, 0);
    chk("halt_freeze", led_run, 8);
    button[4] = 1'b0;
    wait_n(6);
    chk("idle_hold", led_run, 8);
    pulse(2, 3);
    wait_n(2);
    chk("clear_from8", led_run, 0);
    wait_n(4);
    ss_seen = 0;
    for (int p = 0; p < 3; p++) begin
      button[1] = 1'b1;
      steps = 0;
      for (int k = 1; k <= 10; k++) begin
        wait_n(1);
        if (k == 3) button[1] = 1'b0;
        steps += int'(led_step);
        ss_seen += int'(led_start_stop);
      end
      chk("step_pulse", steps, 1);
      chk("step_count", led_run, p + 1);
    end
    chk("step_no_run", ss_seen, 0);
    pulse(2, 3);
    wait_n(2);
    chk("clear_from3", led_run, 0);
    wait_n(6);
    // one-cycle glitch never survives debounce
    ss_seen = 0;
    button[0] = 1'b1;
    wait_n(1);
    button[0] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      wait_n(1);
      ss_seen += int'(led_start_stop);
    end
    chk("glitch_ss", ss_seen, 0);
    chk("glitch_run", led_run, 0);
    pulse(0, 3);
    wait_n(2);
    chk("rerun_ss", led_start_stop, 1);
    wait_n(3);
    chk("rerun_count", led_run, 3);
    resetn = 1'b1;
    wait_n(1);
    chk("midrun_rst_ss", led_start_stop, 0);
    chk("midrun_rst_run", led_run, 0);
    chk("midrun_rst_step", led_step, 0);
    resetn = 1'b0;
    wait_n(4);
    // start and step together: start wins, no step pulse
    button[1:0] = 2'b11;
    steps = 0;
    for (int k = 1; k <= 10; k++) begin
      wait_n(1);
      if (k == 3) button[1:0] = 2'b00;
      steps += int'(led_step);
      if (k == 5) begin
        chk("dual_ss", led_start_stop, 1);
        chk("dual_run0", led_run, 0);
      end
    end
    chk("dual_no_step", steps, 0);
    chk("dual_running", led_run, 5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
